// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: TX state encoding, register map
// indices, control/status bit positions, divisor helper.
package uart_tx_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'h1,
    ST_START     = 4'h2,
    ST_SEND_BYTE = 4'h4,
    ST_STOP      = 4'h8
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    UART_CTRL   = 3'd0,
    UART_STATUS = 3'd1,
    UART_BAUD   = 3'd2,
    UART_TXDATA = 3'd3,
    UART_RXDATA = 3'd4
  } uart_reg_t;

  localparam int CTRL_TX_EN     = 0;
  localparam int STATUS_TX_BUSY = 0;

  // A zero divisor would never expire; run it as one cycle/bit.
  function automatic logic [31:0] eff_div(
    input logic [31:0] d
  );
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Synchronous FIFO, registered pointers and occupancy count.
// Ports: clk, rst (sync, active-low), push/din, pop/dout
// (dout shows head), full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: FIFO-buffered bytes sent as 8N1.
// Ports: clk, rst, tx_en, baud_div, wr_valid/wr_data/wr_ready,
// busy, fifo_level, txd (idle high).
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_en,
  input  logic [31:0]                  baud_div,
  input  logic                         wr_valid,
  input  logic [7:0]                   wr_data,
  output logic                         wr_ready,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         txd
);

  uart_tx_state_t state_q;
  logic           txd_q;
  logic [31:0]    baud_cnt_q;
  logic [31:0]    div_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;

  logic           f_full;
  logic           f_empty;
  logic [7:0]     f_dout;
  logic           baud_done;
  logic           can_start;
  logic           pop_c;
  logic [31:0]    div_eff;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (pop_c),
    .din   (wr_data),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (fifo_level)
  );

  assign baud_done = (baud_cnt_q == 32'd0);
  assign can_start = tx_en && !f_empty;
  assign div_eff   = eff_div(baud_div);

  // Head is consumed only when a frame starts, either from
  // idle or straight out of a stop bit (no idle gap).
  assign pop_c = can_start &&
    ((state_q == ST_IDLE) ||
     ((state_q == ST_STOP) && baud_done));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      txd_q      <= 1'b1;
      baud_cnt_q <= 32'd0;
      div_q      <= 32'(DEFAULT_DIV);
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (pop_c) begin
            state_q    <= ST_START;
            txd_q      <= 1'b0;
            shift_q    <= f_dout;
            div_q      <= div_eff;
            baud_cnt_q <= div_eff - 32'd1;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state_q    <= ST_SEND_BYTE;
            txd_q      <= shift_q[0];
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= div_q - 32'd1;
          end else begin
            baud_cnt_q <= baud_cnt_q - 32'd1;
          end
        end
        ST_SEND_BYTE: begin
          if (baud_done) begin
            baud_cnt_q <= div_q - 32'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 32'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            if (pop_c) begin
              state_q    <= ST_START;
              txd_q      <= 1'b0;
              shift_q    <= f_dout;
              div_q      <= div_eff;
              baud_cnt_q <= div_eff - 32'd1;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign wr_ready = !f_full;
  assign busy     = (state_q != ST_IDLE) || !f_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: queued expected frames
// are checked by a line monitor that decodes txd.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_en = 1'b0;
  logic [31:0] baud_div = 32'd4;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_ready;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        txd;

  uart_tx_ctrl #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (868)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: bytes queued for transmission with the
  // bit period each frame should use.
  logic [7:0] exp_q[$];
  int         expdiv_q[$];
  int         accepted = 0;
  int         starts = 0;

  // Line monitor state
  bit         in_frame = 0;
  bit         post_chk = 0;
  bit         mon_flush = 0;
  int         cyc, cdiv, bad, mb;
  int         gap = 0;
  int         last_gap = 0;
  logic [7:0] cur;
  logic [7:0] obs;
  logic       me;

  always @(negedge clk) begin
    if (mon_flush) begin
      in_frame = 0;
      post_chk = 0;
      gap = 0;
    end else begin
      if (post_chk) begin
        post_chk = 0;
        if (exp_q.size() == 0)
          chk("busy_after_stop", busy, 0);
      end
      if (!in_frame) begin
        if (txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", txd, 1);
          end else begin
            cur = exp_q.pop_front();
            cdiv = expdiv_q.pop_front();
            in_frame = 1;
            cyc = 0;
            bad = 0;
            last_gap = gap;
            starts++;
          end
        end else begin
          gap++;
        end
      end
      if (in_frame) begin
        mb = cyc / cdiv;
        if (mb == 0) me = 1'b0;
        else if (mb == 9) me = 1'b1;
        else me = cur[mb-1];
        if (txd !== me) bad++;
        if (mb >= 1 && mb <= 8 && (cyc % cdiv) == cdiv / 2)
          obs[mb-1] = txd;
        cyc++;
        if (cyc == 10 * cdiv) begin
          in_frame = 0;
          gap = 0;
          post_chk = 1;
          chk("frame_bits", bad, 0);
          chk("frame_data", obs, cur);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    logic acc;
    acc = (accepted - starts) < 4;
    chk("wr_ready", wr_ready, acc);
    wr_valid = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(d);
      expdiv_q.push_back(baud_div == 0 ? 1 : int'(baud_div));
      accepted++;
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy)
           && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, n < budget, 1);
  endtask

  task automatic wait_start(input int s0, input string nm);
    int n = 0;
    while (starts <= s0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, starts > s0, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single 0x55 frame, 4 cycles/bit
    tx_en = 1'b1;
    baud_div = 32'd4;
    push(8'h55);
    wait_idle(200, "t1_done");

    // Back-to-back frames, 2 cycles/bit
    baud_div = 32'd2;
    push(8'hA5);
    push(8'h3C);
    wait_idle(200, "t2_done");
    chk("t2_no_gap", last_gap, 0);

    // Fill while disabled; fifth byte is dropped
    tx_en = 1'b0;
    baud_div = 32'd3;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    repeat (20) @(negedge clk);
    #1;
    chk("t3_level", fifo_level, 4);
    chk("t3_wr_ready", wr_ready, 0);
    chk("t3_busy", busy, 1);
    chk("t3_txd_idle", txd, 1);
    tx_en = 1'b1;
    wait_idle(400, "t3_done");
    chk("t3_level_empty", fifo_level, 0);
    repeat (40) @(negedge clk);
    #1;

    // Divisor 0 and 1 both give one-cycle bits
    baud_div = 32'd0;
    push(8'hFF);
    wait_idle(100, "t4_div0_done");
    baud_div = 32'd1;
    push(8'hFF);
    wait_idle(100, "t4_div1_done");

    // Divisor change mid-frame only affects the next frame
    baud_div = 32'd4;
    s0 = starts;
    push(8'h96);
    wait_start(s0, "t5_start");
    repeat (5) @(negedge clk);
    #1;
    baud_div = 32'd8;
    push(8'h3B);
    wait_idle(300, "t5_done");

    // Disable mid-frame: frame finishes, next byte waits
    baud_div = 32'd2;
    s0 = starts;
    push(8'hE1);
    push(8'h4D);
    wait_start(s0, "t7_start");
    tx_en = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("t7_level", fifo_level, 1);
    chk("t7_busy", busy, 1);
    chk("t7_txd", txd, 1);
    tx_en = 1'b1;
    wait_idle(200, "t7_done");

    // Reset mid SEND_BYTE with two bytes queued
    baud_div = 32'd4;
    s0 = starts;
    push(8'hC3);
    push(8'h5A);
    push(8'h7E);
    wait_start(s0, "t6_start");
    repeat (20) @(negedge clk);
    #1;
    mon_flush = 1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("t6_txd", txd, 1);
    chk("t6_busy", busy, 0);
    chk("t6_level", fifo_level, 0);
    exp_q.delete();
    expdiv_q.delete();
    accepted = starts;
    @(negedge clk);
    #1;
    mon_flush = 0;
    repeat (60) @(negedge clk);
    #1;
    chk("t6_quiet_txd", txd, 1);
    chk("t6_quiet_busy", busy, 0);

    // Randomised bursts
    for (int k = 0; k < 8; k++) begin
      int n;
      baud_div = $urandom_range(0, 5);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        push(8'($urandom));
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle(2000, "rand_done");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
